// File: rtl/dmem_axi_bridge_pkg.sv
// Shared types and AXI4 constants for the MEM-stage data-memory to AXI bridge.
// Holds the FSM state encoding, the size/burst/response codes and the default transaction ID.
package dmem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;

  // Byte access is the fallback when neither width flag is set.
  function automatic logic [2:0] access_size(input logic word, input logic half);
    if (word) begin
      access_size = AXI_SIZE_WORD;
    end else if (half) begin
      access_size = AXI_SIZE_HALF;
    end else begin
      access_size = AXI_SIZE_BYTE;
    end
  endfunction

endpackage

// File: rtl/dmem_axi_bridge.sv
// Uncached data-side bridge: turns one held MEM-stage request into a single-beat AXI4 read or write
// and presents a held completion until MEM consumes it. One transaction outstanding at a time.
module dmem_axi_bridge
  import dmem_axi_bridge_pkg::*;
#(
  parameter int unsigned         ADDR_W = 32,
  parameter int unsigned         DATA_W = 32,
  parameter int unsigned         ID_W   = 4,
  parameter logic [ID_W-1:0]     AXI_ID = ID_W'(AXI_ID_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                mem_word,
  input  logic                mem_halfword,
  input  logic                mem_fire,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_valid,
  output logic                write_finish,
  output logic                bus_err,

  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,

  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata_axi,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,

  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,

  output logic [DATA_W-1:0]   wdata_axi,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,

  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_e                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic [2:0]            size_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  rdata_valid_q;
  logic                  write_finish_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  abandon_q;

  logic                  abandon_d;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  aw_done_d;
  logic                  w_done_d;
  logic [2:0]            size_d;

  // Once MEM drops en mid-flight the request is gone; the bus side still finishes cleanly.
  assign abandon_d = abandon_q | ~en;
  assign aw_fire   = awvalid_q & awready;
  assign w_fire    = wvalid_q & wready;
  assign aw_done_d = aw_done_q | aw_fire;
  assign w_done_d  = w_done_q | w_fire;
  assign size_d    = access_size(mem_word, mem_halfword);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      size_q         <= AXI_SIZE_BYTE;
      rdata_q        <= '0;
      rdata_valid_q  <= 1'b0;
      write_finish_q <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      abandon_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            addr_q    <= addr;
            wdata_q   <= wdata;
            wmask_q   <= wmask;
            size_q    <= size_d;
            abandon_q <= 1'b0;
            if (we) begin
              state_q   <= ST_WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= ST_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        ST_RD_ADDR: begin
          abandon_q <= abandon_d;
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          abandon_q <= abandon_d;
          if (rvalid) begin
            rready_q <= 1'b0;
            if (abandon_d) begin
              state_q <= ST_IDLE;
            end else begin
              rdata_q       <= rdata_axi;
              rdata_valid_q <= 1'b1;
              state_q       <= ST_DONE;
            end
          end
        end

        // AW and W handshake independently; either order or both together is fine.
        ST_WR_REQ: begin
          abandon_q <= abandon_d;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_fire) begin
            awvalid_q <= 1'b0;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          abandon_q <= abandon_d;
          if (bvalid) begin
            bready_q <= 1'b0;
            if (abandon_d) begin
              state_q <= ST_IDLE;
            end else begin
              write_finish_q <= 1'b1;
              state_q        <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (mem_fire || !en) begin
            rdata_valid_q  <= 1'b0;
            write_finish_q <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata        = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign write_finish = write_finish_q;

  // Error flag is tied to the response handshake itself, so it lines up with the accepted beat.
  assign bus_err = reset & ((rvalid & rready_q & rresp[1]) | (bvalid & bready_q & bresp[1]));

  assign arid      = AXI_ID;
  assign araddr    = addr_q;
  assign arsize    = size_q;
  assign arlen     = AXI_LEN_SINGLE;
  assign arburst   = AXI_BURST_INCR;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

  assign awid      = AXI_ID;
  assign awaddr    = addr_q;
  assign awsize    = size_q;
  assign awlen     = AXI_LEN_SINGLE;
  assign awburst   = AXI_BURST_INCR;
  assign awvalid   = awvalid_q;

  assign wdata_axi = wdata_q;
  assign wstrb     = wmask_q;
  assign wlast     = 1'b1;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, rlast, rresp[0], bresp[0]};

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge: loads, stores, abandon, back-pressure, reset and error response.
// The AXI slave side is driven by hand, cycle by cycle, with expected values written out per step.
module tb_dmem_axi_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        en;
  logic        we;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        mem_word;
  logic        mem_halfword;
  logic        mem_fire;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        write_finish;
  logic        bus_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata_axi;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int testCount = 0;
  int failCount = 0;
  int arCount   = 0;
  int awCount   = 0;
  int wCount    = 0;

  dmem_axi_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .en           (en),
    .we           (we),
    .wmask        (wmask),
    .wdata        (wdata),
    .mem_word     (mem_word),
    .mem_halfword (mem_halfword),
    .mem_fire     (mem_fire),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .write_finish (write_finish),
    .bus_err      (bus_err),
    .arid         (arid),
    .araddr       (araddr),
    .arsize       (arsize),
    .arlen        (arlen),
    .arburst      (arburst),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata_axi    (rdata_axi),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready),
    .awid         (awid),
    .awaddr       (awaddr),
    .awsize       (awsize),
    .awlen        (awlen),
    .awburst      (awburst),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata_axi    (wdata_axi),
    .wstrb        (wstrb),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bid          (bid),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake tallies catch duplicated or missing address/data beats.
  always @(posedge clk) begin
    if (reset) begin
      if (arvalid && arready) arCount++;
      if (awvalid && awready) awCount++;
      if (wvalid && wready) wCount++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic reqEn, input logic reqWe, input logic [31:0] reqAddr,
                               input logic [3:0] reqMask, input logic [31:0] reqData,
                               input logic reqWord, input logic reqHalf);
    en           = reqEn;
    we           = reqWe;
    addr         = reqAddr;
    wmask        = reqMask;
    wdata        = reqData;
    mem_word     = reqWord;
    mem_halfword = reqHalf;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b0;
    mem_fire  = 1'b0;
    arready   = 1'b0;
    rid       = 4'd0;
    rdata_axi = 32'h0;
    rresp     = 2'b00;
    rlast     = 1'b1;
    rvalid    = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bid       = 4'd0;
    bresp     = 2'b00;
    bvalid    = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("rst_rready", 64'(rready), 64'd0);
    checkOutput("rst_awvalid", 64'(awvalid), 64'd0);
    checkOutput("rst_wvalid", 64'(wvalid), 64'd0);
    checkOutput("rst_bready", 64'(bready), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_rdata_valid", 64'(rdata_valid), 64'd0);
    checkOutput("rst_write_finish", 64'(write_finish), 64'd0);
    checkOutput("rst_bus_err", 64'(bus_err), 64'd0);
    reset = 1'b1;
    tick();

    // Word load with zero-wait slave
    applyStimulus(1'b1, 1'b0, 32'h1C00_0010, 4'hF, 32'h0, 1'b1, 1'b0);
    checkOutput("lw_idle_arvalid", 64'(arvalid), 64'd0);
    tick();
    checkOutput("lw_arvalid", 64'(arvalid), 64'd1);
    checkOutput("lw_araddr", 64'(araddr), 64'h1C00_0010);
    checkOutput("lw_arsize", 64'(arsize), 64'd2);
    checkOutput("lw_arlen", 64'(arlen), 64'd0);
    checkOutput("lw_arburst", 64'(arburst), 64'd1);
    checkOutput("lw_arid", 64'(arid), 64'd1);
    checkOutput("lw_rready_early", 64'(rready), 64'd0);
    arready = 1'b1;
    tick();
    checkOutput("lw_arvalid_drop", 64'(arvalid), 64'd0);
    checkOutput("lw_rready", 64'(rready), 64'd1);
    checkOutput("lw_valid_early", 64'(rdata_valid), 64'd0);
    arready   = 1'b0;
    rvalid    = 1'b1;
    rdata_axi = 32'hDEAD_BEEF;
    rresp     = 2'b00;
    #1;
    checkOutput("lw_bus_err_okay", 64'(bus_err), 64'd0);
    tick();
    checkOutput("lw_rdata_valid", 64'(rdata_valid), 64'd1);
    checkOutput("lw_rdata", 64'(rdata), 64'hDEAD_BEEF);
    checkOutput("lw_rready_drop", 64'(rready), 64'd0);
    rvalid   = 1'b0;
    mem_fire = 1'b1;
    tick();
    checkOutput("lw_fire_release", 64'(rdata_valid), 64'd0);
    mem_fire = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("lw_idle_after", 64'(arvalid), 64'd0);

    // Byte store, W accepted two cycles before AW
    applyStimulus(1'b1, 1'b1, 32'h1C00_0003, 4'b1000, 32'hAB00_0000, 1'b0, 1'b0);
    tick();
    checkOutput("sb_awvalid", 64'(awvalid), 64'd1);
    checkOutput("sb_wvalid", 64'(wvalid), 64'd1);
    checkOutput("sb_awsize", 64'(awsize), 64'd0);
    checkOutput("sb_awaddr", 64'(awaddr), 64'h1C00_0003);
    checkOutput("sb_wstrb", 64'(wstrb), 64'h8);
    checkOutput("sb_wdata", 64'(wdata_axi), 64'hAB00_0000);
    checkOutput("sb_wlast", 64'(wlast), 64'd1);
    checkOutput("sb_awlen", 64'(awlen), 64'd0);
    checkOutput("sb_awburst", 64'(awburst), 64'd1);
    checkOutput("sb_awid", 64'(awid), 64'd1);
    wready = 1'b1;
    tick();
    checkOutput("sb_wvalid_drop", 64'(wvalid), 64'd0);
    checkOutput("sb_awvalid_hold1", 64'(awvalid), 64'd1);
    checkOutput("sb_bready_early", 64'(bready), 64'd0);
    wready = 1'b0;
    tick();
    checkOutput("sb_awvalid_hold2", 64'(awvalid), 64'd1);
    checkOutput("sb_wvalid_stays_low", 64'(wvalid), 64'd0);
    awready = 1'b1;
    tick();
    checkOutput("sb_awvalid_drop", 64'(awvalid), 64'd0);
    checkOutput("sb_bready", 64'(bready), 64'd1);
    checkOutput("sb_finish_early", 64'(write_finish), 64'd0);
    awready = 1'b0;
    bvalid  = 1'b1;
    bresp   = 2'b00;
    tick();
    checkOutput("sb_write_finish", 64'(write_finish), 64'd1);
    checkOutput("sb_bready_drop", 64'(bready), 64'd0);
    checkOutput("sb_aw_count", 64'(awCount), 64'd1);
    checkOutput("sb_w_count", 64'(wCount), 64'd1);
    bvalid   = 1'b0;
    mem_fire = 1'b1;
    tick();
    checkOutput("sb_fire_release", 64'(write_finish), 64'd0);
    mem_fire = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    tick();

    // Load abandoned while R is delayed
    applyStimulus(1'b1, 1'b0, 32'h1C00_0020, 4'hF, 32'h0, 1'b1, 1'b0);
    arready = 1'b1;
    tick();
    checkOutput("ab_arvalid", 64'(arvalid), 64'd1);
    tick();
    checkOutput("ab_rready", 64'(rready), 64'd1);
    checkOutput("ab_arvalid_drop", 64'(arvalid), 64'd0);
    arready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h1C00_0020, 4'hF, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("ab_rready_hold%0d", i), 64'(rready), 64'd1);
    end
    rvalid    = 1'b1;
    rdata_axi = 32'h1234_5678;
    tick();
    checkOutput("ab_rready_drop", 64'(rready), 64'd0);
    checkOutput("ab_no_valid", 64'(rdata_valid), 64'd0);
    rvalid = 1'b0;
    tick();
    checkOutput("ab_no_valid_later", 64'(rdata_valid), 64'd0);
    checkOutput("ab_idle_arvalid", 64'(arvalid), 64'd0);
    checkOutput("ab_ar_count", 64'(arCount), 64'd2);

    // Fresh halfword load, then completion held under back-pressure
    applyStimulus(1'b1, 1'b0, 32'h1C00_0042, 4'hF, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("lh_arvalid", 64'(arvalid), 64'd1);
    checkOutput("lh_araddr", 64'(araddr), 64'h1C00_0042);
    checkOutput("lh_arsize", 64'(arsize), 64'd1);
    arready = 1'b1;
    tick();
    arready   = 1'b0;
    rvalid    = 1'b1;
    rdata_axi = 32'h55AA_55AA;
    tick();
    rvalid = 1'b0;
    checkOutput("bp_rdata", 64'(rdata), 64'h55AA_55AA);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), 64'(rdata_valid), 64'd1);
      checkOutput($sformatf("bp_no_ar%0d", i), 64'(arvalid), 64'd0);
      if (i < 2) tick();
    end
    mem_fire = 1'b1;
    tick();
    checkOutput("bp_release", 64'(rdata_valid), 64'd0);
    mem_fire = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_ar_count", 64'(arCount), 64'd3);

    // Reset while waiting for B
    applyStimulus(1'b1, 1'b1, 32'h1C00_0080, 4'hF, 32'h1122_3344, 1'b1, 1'b0);
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    checkOutput("rs_awsize", 64'(awsize), 64'd2);
    checkOutput("rs_awvalid", 64'(awvalid), 64'd1);
    tick();
    checkOutput("rs_bready", 64'(bready), 64'd1);
    checkOutput("rs_both_dropped", 64'({awvalid, wvalid}), 64'd0);
    awready = 1'b0;
    wready  = 1'b0;
    reset   = 1'b0;
    tick();
    checkOutput("rs_bready_reset", 64'(bready), 64'd0);
    checkOutput("rs_valids_reset", 64'({arvalid, awvalid, wvalid, rready}), 64'd0);
    checkOutput("rs_rdata_reset", 64'(rdata), 64'd0);
    checkOutput("rs_completion_reset", 64'({rdata_valid, write_finish, bus_err}), 64'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("rs_no_finish", 64'(write_finish), 64'd0);
    checkOutput("rs_idle_bready", 64'(bready), 64'd0);

    // Word store with SLVERR response, AW accepted before W
    applyStimulus(1'b1, 1'b1, 32'h1C00_0100, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0);
    tick();
    checkOutput("er_wdata", 64'(wdata_axi), 64'hCAFE_F00D);
    awready = 1'b1;
    tick();
    checkOutput("er_awvalid_drop", 64'(awvalid), 64'd0);
    checkOutput("er_wvalid_hold", 64'(wvalid), 64'd1);
    awready = 1'b0;
    wready  = 1'b1;
    tick();
    checkOutput("er_wvalid_drop", 64'(wvalid), 64'd0);
    checkOutput("er_bready", 64'(bready), 64'd1);
    wready = 1'b0;
    bvalid = 1'b1;
    bresp  = 2'b10;
    #1;
    checkOutput("er_bus_err_pulse", 64'(bus_err), 64'd1);
    tick();
    checkOutput("er_write_finish", 64'(write_finish), 64'd1);
    checkOutput("er_bus_err_clear", 64'(bus_err), 64'd0);
    bvalid = 1'b0;
    bresp  = 2'b00;
    mem_fire = 1'b1;
    tick();
    checkOutput("er_release", 64'(write_finish), 64'd0);
    checkOutput("er_aw_count", 64'(awCount), 64'd3);
    checkOutput("er_w_count", 64'(wCount), 64'd3);
    mem_fire = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
